// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module      : reset_sequencer
//  Description : Staged active-low reset generator. A raw asynchronous
//                active-high reset clears every output at once; the outputs
//                are then released one domain at a time, synchronously to
//                clk, after a hold period. A software re-reset request is
//                accepted while running and acknowledged with a 1-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_GAP   = 4,
   parameter int NUM_OUT     = 3,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sw_req,
   output logic [NUM_OUT-1:0] rst_n_out,
   output logic               all_ready,
   output logic               sw_ack,
   output logic               busy
);

   localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_OUT - 1);
   localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

   // Elaboration-time guard on the legal parameter ranges.
   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("reset_sequencer: SYNC_STAGES must be >= 2");
      end
      if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
         $error("reset_sequencer: HOLD_CYCLES must be >= 1");
      end
      if (STAGE_GAP < 1) begin : g_bad_stage_gap
         $error("reset_sequencer: STAGE_GAP must be >= 1");
      end
      if (NUM_OUT < 1) begin : g_bad_num_out
         $error("reset_sequencer: NUM_OUT must be >= 1");
      end
      if ((HOLD_CYCLES >= (1 << CNT_W)) || (STAGE_GAP >= (1 << CNT_W))) begin : g_bad_cnt_w
         $error("reset_sequencer: CNT_W too narrow for HOLD_CYCLES/STAGE_GAP");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   state_t                 state_q,     state_d;
   logic [SYNC_STAGES-1:0] sync_q,      sync_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic [IDX_W-1:0]       idx_q,       idx_d;
   logic [NUM_OUT-1:0]     rst_n_out_q, rst_n_out_d;
   logic                   all_ready_q, all_ready_d;
   logic                   sw_ack_q,    sw_ack_d;
   logic                   busy_q,      busy_d;

   logic                   sync_done;

   // Release synchronizer: shifts in ones once the raw reset is gone.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign sync_done = sync_q[SYNC_STAGES-1];

   // Next-state, counters and registered-output values for the sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_n_out_d = rst_n_out_q;
      all_ready_d = all_ready_q;
      sw_ack_d    = 1'b0;

      case (state_q)
         ST_SYNC: begin
            if (sync_done) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end

         ST_HOLD: begin
            if (cnt_q == C_HOLD_LAST) begin
               rst_n_out_d = NUM_OUT'(1);
               cnt_d       = '0;
               if (NUM_OUT == 1) begin
                  state_d     = ST_RUN;
                  all_ready_d = 1'b1;
               end else begin
                  idx_d   = C_IDX_ONE;
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RELEASE: begin
            if (cnt_q == C_GAP_LAST) begin
               // Released bits always form a contiguous run from bit 0, so
               // shifting in a one sets exactly bit idx.
               rst_n_out_d = (rst_n_out_q << 1) | NUM_OUT'(1);
               cnt_d       = '0;
               idx_d       = idx_q + 1'b1;
               if (idx_q == C_IDX_LAST) begin
                  state_d     = ST_RUN;
                  all_ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            rst_n_out_d = '1;
            if (sw_req) begin
               // Re-reset skips the synchronizer: clk is known good here.
               rst_n_out_d = '0;
               all_ready_d = 1'b0;
               sw_ack_d    = 1'b1;
               cnt_d       = '0;
               idx_d       = '0;
               state_d     = ST_HOLD;
            end
         end

         default: begin
            state_d = ST_SYNC;
         end
      endcase

      busy_d = (state_d != ST_RUN);
   end

   // State and output registers; raw reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SYNC;
         sync_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_n_out_q <= '0;
         all_ready_q <= 1'b0;
         sw_ack_q    <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_n_out_q <= rst_n_out_d;
         all_ready_q <= all_ready_d;
         sw_ack_q    <= sw_ack_d;
         busy_q      <= busy_d;
      end
   end

   assign rst_n_out = rst_n_out_q;
   assign all_ready = all_ready_q;
   assign sw_ack    = sw_ack_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire
